// File: rtl/vga_marker_decoder.sv
// vga_marker_decoder: decodes a checkerboard VGA frame carrying one red marker block.
// Ports: Clock, Reset (async, active-low), iVGAColor/iVGAHorizontalSync/iVGAVerticalSync in;
//        oMarkedBlockPosX/Y, oMarkValid, oFrameError, oFrameDone, oLocked out.
module vga_marker_decoder #(
  parameter int X_WIDTH       = 8,
  parameter int Y_WIDTH       = 8,
  parameter int X_SIZE        = 256,
  parameter int Y_SIZE        = 256,
  parameter int BLOCK_WIDTH_X = 64,
  parameter int BLOCK_WIDTH_Y = 64,
  parameter int H_OFFSET      = 48,
  parameter int V_OFFSET      = 33
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic [2:0] iVGAColor,
  input  logic       iVGAHorizontalSync,
  input  logic       iVGAVerticalSync,
  output logic [2:0] oMarkedBlockPosX,
  output logic [2:0] oMarkedBlockPosY,
  output logic       oMarkValid,
  output logic       oFrameError,
  output logic       oFrameDone,
  output logic       oLocked
);

  // Counters are one bit wider than the active window end so they
  // can sit in blanking (saturated) without aliasing into the window.
  localparam int HCW = $clog2(H_OFFSET + X_SIZE + 1) + 1;
  localparam int VCW = $clog2(V_OFFSET + Y_SIZE + 1) + 1;
  localparam int RCW = $clog2(X_SIZE * Y_SIZE + 1);

  localparam logic [HCW-1:0] H_LO = HCW'(H_OFFSET);
  localparam logic [HCW-1:0] H_HI = HCW'(H_OFFSET + X_SIZE);
  localparam logic [VCW-1:0] V_LO = VCW'(V_OFFSET);
  localparam logic [VCW-1:0] V_HI = VCW'(V_OFFSET + Y_SIZE);
  localparam logic [X_WIDTH-1:0] BWX = X_WIDTH'(BLOCK_WIDTH_X);
  localparam logic [Y_WIDTH-1:0] BWY = Y_WIDTH'(BLOCK_WIDTH_Y);
  localparam logic [RCW-1:0] AREA = RCW'(BLOCK_WIDTH_X * BLOCK_WIDTH_Y);

  typedef enum logic {
    ACQUIRE,
    SCAN
  } state_t;

  state_t state_q, state_d;

  logic [2:0]     rgb_q;
  logic           hs_q, vs_q, hs2_q, vs2_q;
  logic           hs_fall, vs_fall;
  logic [HCW-1:0] hcnt_q;
  logic [VCW-1:0] vcnt_q;

  logic               active, acc_en, snap;
  logic [X_WIDTH-1:0] col;
  logic [Y_WIDTH-1:0] row;
  logic [2:0]         bx, by, exp_rgb;
  logic               is_red, is_bad;

  logic           err_q, cand_v_q;
  logic [2:0]     cx_q, cy_q;
  logic [RCW-1:0] rcnt_q;

  logic           s_err_q, eval_q;
  logic [2:0]     s_x_q, s_y_q;
  logic [RCW-1:0] s_cnt_q;
  logic           f_err, f_valid;

  logic [1:0] ok_q, ok_inc;
  logic [2:0] pos_x_q, pos_y_q;
  logic       valid_q, ferr_q, done_q, locked_q;

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      rgb_q <= '0;
      hs_q  <= 1'b1;
      vs_q  <= 1'b1;
      hs2_q <= 1'b1;
      vs2_q <= 1'b1;
    end else begin
      rgb_q <= iVGAColor;
      hs_q  <= iVGAHorizontalSync;
      vs_q  <= iVGAVerticalSync;
      hs2_q <= hs_q;
      vs2_q <= vs_q;
    end
  end

  assign hs_fall = hs2_q & ~hs_q;
  assign vs_fall = vs2_q & ~vs_q;

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      hcnt_q <= '0;
      vcnt_q <= '0;
    end else begin
      if (hs_fall) hcnt_q <= '0;
      else if (hcnt_q != '1) hcnt_q <= hcnt_q + 1'b1;
      if (vs_fall) vcnt_q <= '0;
      else if (hs_fall && vcnt_q != '1) vcnt_q <= vcnt_q + 1'b1;
    end
  end

  always_comb begin
    active  = (hcnt_q >= H_LO) && (hcnt_q < H_HI) &&
              (vcnt_q >= V_LO) && (vcnt_q < V_HI);
    col     = X_WIDTH'(hcnt_q - H_LO);
    row     = Y_WIDTH'(vcnt_q - V_LO);
    bx      = 3'(col / BWX);
    by      = 3'(row / BWY);
    exp_rgb = (bx[0] ^ by[0]) ? 3'b111 : 3'b000;
    is_red  = (rgb_q == 3'b100);
    is_bad  = !is_red && (rgb_q != exp_rgb);
    acc_en  = (state_q == SCAN) && active && !vs_fall;
  end

  always_comb begin
    state_d = state_q;
    snap    = 1'b0;
    unique case (state_q)
      ACQUIRE: if (vs_fall) state_d = SCAN;
      SCAN:    if (vs_fall) snap = 1'b1;
      default: state_d = ACQUIRE;
    endcase
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) state_q <= ACQUIRE;
    else        state_q <= state_d;
  end

  // Accumulators restart on every vsync fall; the finished frame is
  // snapshotted in the same edge so evaluation never races the new frame.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      err_q    <= 1'b0;
      cand_v_q <= 1'b0;
      cx_q     <= '0;
      cy_q     <= '0;
      rcnt_q   <= '0;
    end else if (vs_fall) begin
      err_q    <= 1'b0;
      cand_v_q <= 1'b0;
      cx_q     <= '0;
      cy_q     <= '0;
      rcnt_q   <= '0;
    end else if (acc_en) begin
      if (is_bad) err_q <= 1'b1;
      if (is_red) begin
        rcnt_q <= rcnt_q + RCW'(1);
        if (!cand_v_q) begin
          cand_v_q <= 1'b1;
          cx_q     <= bx;
          cy_q     <= by;
        end else if ({bx, by} != {cx_q, cy_q}) begin
          err_q <= 1'b1;
        end
      end
    end
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      s_err_q <= 1'b0;
      s_x_q   <= '0;
      s_y_q   <= '0;
      s_cnt_q <= '0;
      eval_q  <= 1'b0;
    end else begin
      eval_q <= snap;
      if (snap) begin
        s_err_q <= err_q;
        s_x_q   <= cx_q;
        s_y_q   <= cy_q;
        s_cnt_q <= rcnt_q;
      end
    end
  end

  always_comb begin
    f_err   = s_err_q | ((s_cnt_q != '0) && (s_cnt_q != AREA));
    f_valid = !f_err && (s_cnt_q == AREA);
    ok_inc  = (ok_q == 2'd3) ? ok_q : ok_q + 2'd1;
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      done_q   <= 1'b0;
      ferr_q   <= 1'b0;
      valid_q  <= 1'b0;
      pos_x_q  <= '0;
      pos_y_q  <= '0;
      ok_q     <= '0;
      locked_q <= 1'b0;
    end else begin
      done_q <= eval_q;
      if (eval_q) begin
        ferr_q  <= f_err;
        valid_q <= f_valid;
        if (f_valid) begin
          pos_x_q <= s_x_q;
          pos_y_q <= s_y_q;
        end
        if (f_err) begin
          ok_q     <= '0;
          locked_q <= 1'b0;
        end else begin
          ok_q     <= ok_inc;
          locked_q <= (ok_inc >= 2'd2);
        end
      end
    end
  end

  assign oMarkedBlockPosX = pos_x_q;
  assign oMarkedBlockPosY = pos_y_q;
  assign oMarkValid       = valid_q;
  assign oFrameError      = ferr_q;
  assign oFrameDone       = done_q;
  assign oLocked          = locked_q;

endmodule

// File: tb/tb_vga_marker_decoder.sv
// tb_vga_marker_decoder: directed frames on a reduced geometry (32x16, 4x4 blocks)
// with a scoreboard of per-frame expected results checked at each oFrameDone.
module tb_vga_marker_decoder;

  localparam int XW = 5;
  localparam int YW = 4;
  localparam int XS = 32;
  localparam int YS = 16;
  localparam int BX = 4;
  localparam int BY = 4;
  localparam int HO = 4;
  localparam int VO = 2;
  localparam int LINE = HO + 1 + XS + 3;
  localparam int NL = VO + YS + 2;
  // column 0 is driven one clock later than H_OFFSET because the
  // counter clears one clock after the registered hsync fall
  localparam int PIX0 = HO + 1;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] rgb = 3'b000;
  logic       hs = 1'b1;
  logic       vs = 1'b1;
  logic [2:0] pos_x, pos_y;
  logic       mvalid, ferr, done, locked;

  vga_marker_decoder #(
    .X_WIDTH(XW), .Y_WIDTH(YW), .X_SIZE(XS), .Y_SIZE(YS),
    .BLOCK_WIDTH_X(BX), .BLOCK_WIDTH_Y(BY),
    .H_OFFSET(HO), .V_OFFSET(VO)
  ) dut (
    .Clock(clk),
    .Reset(rst_n),
    .iVGAColor(rgb),
    .iVGAHorizontalSync(hs),
    .iVGAVerticalSync(vs),
    .oMarkedBlockPosX(pos_x),
    .oMarkedBlockPosY(pos_y),
    .oMarkValid(mvalid),
    .oFrameError(ferr),
    .oFrameDone(done),
    .oLocked(locked)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;

  task automatic check(input string tag, input int obs, input int exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  typedef struct {
    int due;
    int valid;
    int err;
    int x;
    int y;
    int locked;
  } exp_t;

  exp_t sb[$];

  // picture configuration
  int cfg_rbx, cfg_rby, cfg_hc, cfg_hr, cfg_xc, cfg_xr;
  logic [2:0] cfg_xcol;

  task automatic set_cfg(input int rbx, input int rby, input int hc,
                         input int hr, input int xc, input int xr,
                         input logic [2:0] xcol);
    cfg_rbx = rbx; cfg_rby = rby;
    cfg_hc = hc; cfg_hr = hr;
    cfg_xc = xc; cfg_xr = xr;
    cfg_xcol = xcol;
  endtask

  function automatic logic [2:0] base(input int c, input int r);
    return (((c / BX) ^ (r / BY)) & 1) != 0 ? 3'b111 : 3'b000;
  endfunction

  function automatic logic [2:0] pix(input int c, input int r);
    logic [2:0] p;
    p = base(c, r);
    if (c / BX == cfg_rbx && r / BY == cfg_rby) p = 3'b100;
    if (c == cfg_hc && r == cfg_hr) p = base(c, r);
    if (c == cfg_xc && r == cfg_xr) p = cfg_xcol;
    return p;
  endfunction

  // reference model state
  int raw_v, raw_e, raw_x, raw_y;
  int m_ok = 0, m_x = 0, m_y = 0;
  bit have_prev = 1'b0;

  task automatic compute_raw();
    int cnt, fx, fy;
    bit bad, multi, have;
    cnt = 0; fx = 0; fy = 0;
    bad = 0; multi = 0; have = 0;
    for (int r = 0; r < YS; r++)
      for (int c = 0; c < XS; c++) begin
        logic [2:0] p;
        p = pix(c, r);
        if (p == 3'b100) begin
          cnt++;
          if (!have) begin
            have = 1; fx = c / BX; fy = r / BY;
          end else if (c / BX != fx || r / BY != fy) multi = 1;
        end else if (p != base(c, r)) bad = 1;
      end
    raw_e = (bad || multi || (cnt != 0 && cnt != BX * BY)) ? 1 : 0;
    raw_v = (raw_e == 0 && cnt == BX * BY) ? 1 : 0;
    raw_x = fx;
    raw_y = fy;
  endtask

  task automatic push_prev();
    exp_t e;
    if (raw_e != 0) m_ok = 0;
    else if (m_ok < 3) m_ok++;
    if (raw_v != 0) begin
      m_x = raw_x; m_y = raw_y;
    end
    e.due = cyc + 3;
    e.valid = raw_v;
    e.err = raw_e;
    e.x = m_x;
    e.y = m_y;
    e.locked = (m_ok >= 2) ? 1 : 0;
    sb.push_back(e);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_posx"}, pos_x, 0);
    check({tag, "_posy"}, pos_y, 0);
    check({tag, "_valid"}, mvalid, 0);
    check({tag, "_err"}, ferr, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_locked"}, locked, 0);
  endtask

  task automatic frame(input int rst_line);
    for (int l = 0; l < NL; l++)
      for (int j = 0; j < LINE; j++) begin
        @(posedge clk);
        #1;
        hs = (j < 2) ? 1'b0 : 1'b1;
        vs = (l == 0) ? 1'b0 : 1'b1;
        if (l == 0 && j == 0) begin
          if (have_prev) push_prev();
          compute_raw();
          have_prev = 1'b1;
        end
        if (l >= VO && l < VO + YS && j >= PIX0 && j < PIX0 + XS)
          rgb = pix(j - PIX0, l - VO);
        else
          rgb = 3'b000;
        if (l == rst_line && j == 10) begin
          rst_n = 1'b0;
          #1;
          check_zero("midrst");
          have_prev = 1'b0;
          m_ok = 0; m_x = 0; m_y = 0;
        end
        if (l == rst_line && j == 14) rst_n = 1'b1;
      end
  endtask

  task automatic tail();
    @(posedge clk);
    #1;
    if (have_prev) push_prev();
    have_prev = 1'b0;
    hs = 1'b0;
    vs = 1'b0;
    rgb = 3'b000;
    repeat (LINE) @(posedge clk);
    #1;
    hs = 1'b1;
    vs = 1'b1;
    repeat (20) @(posedge clk);
  endtask

  exp_t mon_e;

  always @(negedge clk) begin
    if (rst_n && done) begin
      if (sb.size() == 0) begin
        check("spurious_done", done, 0);
      end else begin
        mon_e = sb.pop_front();
        check("done_cycle", cyc, mon_e.due);
        check("mark_valid", mvalid, mon_e.valid);
        check("frame_error", ferr, mon_e.err);
        check("pos_x", pos_x, mon_e.x);
        check("pos_y", pos_y, mon_e.y);
        check("locked", locked, mon_e.locked);
      end
    end else if (rst_n && sb.size() > 0 && cyc > sb[0].due) begin
      check("missed_done", done, 1);
      void'(sb.pop_front());
    end
  end

  initial begin
    set_cfg(2, 1, -1, -1, -1, -1, 3'b000);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_zero("reset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // red block (2,1): three frames, lock on the second done
    frame(-1);
    frame(-1);
    frame(-1);
    // extra red pixel in another block
    set_cfg(2, 1, -1, -1, 5, 5, 3'b100);
    frame(-1);
    // clean checkerboard, no marker
    set_cfg(-1, -1, -1, -1, -1, -1, 3'b000);
    frame(-1);
    // single green pixel
    set_cfg(-1, -1, -1, -1, 25, 13, 3'b010);
    frame(-1);
    set_cfg(-1, -1, -1, -1, -1, -1, 3'b000);
    frame(-1);
    // corner block (7,3) with one pixel missing, then complete
    set_cfg(7, 3, 29, 13, -1, -1, 3'b000);
    frame(-1);
    set_cfg(7, 3, -1, -1, -1, -1, 3'b000);
    frame(-1);
    // reset in the middle of a frame, then recover
    set_cfg(2, 1, -1, -1, -1, -1, 3'b000);
    frame(8);
    frame(-1);
    frame(-1);
    tail();

    check("sb_drained", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
